// File: rtl/voice_allocator.sv
// ============================================================================
//  Module      : voice_allocator
//  Description : Polyphonic note-to-voice allocator. Scans eight voices one per
//                cycle, then retriggers, allocates a free voice or steals
//                round-robin, and issues a single update pulse to the gate demux.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module voice_allocator #(
    parameter int NOTE_W     = 7,
    parameter int NUM_VOICES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  note_valid,
    input  logic                  note_on,
    input  logic [NOTE_W-1:0]     note_num,
    output logic                  note_ready,
    output logic                  upd_strobe,
    output logic [2:0]            upd_voice,
    output logic                  upd_gate,
    output logic [NOTE_W-1:0]     upd_note,
    output logic                  upd_steal,
    output logic [NUM_VOICES-1:0] voice_active
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    localparam logic [2:0] c_LAST_VOICE = 3'd7;

    state_t r_state;
    state_t w_state_nxt;

    // Voice table
    logic [NUM_VOICES-1:0] r_active;
    logic [NOTE_W-1:0]     r_note [NUM_VOICES];
    logic [2:0]            r_steal_ptr;

    // Captured event and scan bookkeeping
    logic                  r_cap_on;
    logic [NOTE_W-1:0]     r_cap_note;
    logic [2:0]            r_scan_idx;
    logic                  r_match_found;
    logic [2:0]            r_match_idx;
    logic                  r_free_found;
    logic [2:0]            r_free_idx;

    // Registered outputs
    logic                  r_ready;
    logic                  r_strobe;
    logic [2:0]            r_upd_voice;
    logic                  r_upd_gate;
    logic [NOTE_W-1:0]     r_upd_note;
    logic                  r_upd_steal;

    logic                  w_accept;
    logic                  w_cur_match;
    logic                  w_cur_free;
    logic                  w_match_found;
    logic [2:0]            w_match_idx;
    logic                  w_free_found;
    logic [2:0]            w_free_idx;
    logic                  w_scan_last;
    logic                  w_issue;
    logic                  w_steal;
    logic [2:0]            w_target;

    assign w_accept = (r_state == S_IDLE) && note_valid && r_ready;

    // The voice under examination is folded into the running result so the
    // final decision on the last scan cycle already covers voice 7.
    always_comb begin
        w_cur_match   = r_active[r_scan_idx] && (r_note[r_scan_idx] == r_cap_note);
        w_cur_free    = !r_active[r_scan_idx];
        w_match_found = r_match_found || w_cur_match;
        w_match_idx   = r_match_found ? r_match_idx : r_scan_idx;
        w_free_found  = r_free_found || w_cur_free;
        w_free_idx    = r_free_found ? r_free_idx : r_scan_idx;
        w_scan_last   = (r_state == S_SCAN) && (r_scan_idx == c_LAST_VOICE);
        w_issue       = r_cap_on || w_match_found;
        w_steal       = r_cap_on && !w_match_found && !w_free_found;
        if (w_match_found) begin
            w_target = w_match_idx;
        end else if (w_free_found) begin
            w_target = w_free_idx;
        end else begin
            w_target = r_steal_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_scan_last) begin
                    w_state_nxt = w_issue ? S_ISSUE : S_IDLE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active      <= '0;
            r_steal_ptr   <= 3'd0;
            r_cap_on      <= 1'b0;
            r_cap_note    <= '0;
            r_scan_idx    <= 3'd0;
            r_match_found <= 1'b0;
            r_match_idx   <= 3'd0;
            r_free_found  <= 1'b0;
            r_free_idx    <= 3'd0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cap_on      <= note_on;
                        r_cap_note    <= note_num;
                        r_scan_idx    <= 3'd0;
                        r_match_found <= 1'b0;
                        r_free_found  <= 1'b0;
                    end
                end
                S_SCAN: begin
                    r_match_found <= w_match_found;
                    r_match_idx   <= w_match_idx;
                    r_free_found  <= w_free_found;
                    r_free_idx    <= w_free_idx;
                    r_scan_idx    <= r_scan_idx + 3'd1;
                    // Voice table commits on the edge entering ISSUE so the
                    // gate state is already current while the strobe is high.
                    if (w_scan_last && w_issue) begin
                        r_active[w_target] <= r_cap_on;
                        if (r_cap_on) begin
                            r_note[w_target] <= r_cap_note;
                        end
                        if (w_steal) begin
                            r_steal_ptr <= r_steal_ptr + 3'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready     <= 1'b0;
            r_strobe    <= 1'b0;
            r_upd_voice <= 3'd0;
            r_upd_gate  <= 1'b0;
            r_upd_note  <= '0;
            r_upd_steal <= 1'b0;
        end else begin
            r_ready     <= (w_state_nxt == S_IDLE);
            r_strobe    <= (w_state_nxt == S_ISSUE);
            r_upd_steal <= (w_state_nxt == S_ISSUE) && w_steal;
            if (w_scan_last && w_issue) begin
                r_upd_voice <= w_target;
                r_upd_gate  <= r_cap_on;
                r_upd_note  <= r_cap_note;
            end
        end
    end

    assign note_ready   = r_ready;
    assign upd_strobe   = r_strobe;
    assign upd_voice    = r_upd_voice;
    assign upd_gate     = r_upd_gate;
    assign upd_note     = r_upd_note;
    assign upd_steal    = r_upd_steal;
    assign voice_active = r_active;

endmodule

`default_nettype wire

// File: tb/tb_voice_allocator.sv
// ============================================================================
//  Module      : tb_voice_allocator
//  Description : Directed self-checking bench for voice_allocator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_voice_allocator;

    logic       clk = 1'b0;
    logic       rst;
    logic       note_valid;
    logic       note_on;
    logic [6:0] note_num;
    logic       note_ready;
    logic       upd_strobe;
    logic [2:0] upd_voice;
    logic       upd_gate;
    logic [6:0] upd_note;
    logic       upd_steal;
    logic [7:0] voice_active;

    int n_checks = 0;
    int n_fail   = 0;

    voice_allocator #(.NOTE_W(7), .NUM_VOICES(8)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .note_valid   (note_valid),
        .note_on      (note_on),
        .note_num     (note_num),
        .note_ready   (note_ready),
        .upd_strobe   (upd_strobe),
        .upd_voice    (upd_voice),
        .upd_gate     (upd_gate),
        .upd_note     (upd_note),
        .upd_steal    (upd_steal),
        .voice_active (voice_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40 && !note_ready; i++) @(negedge clk);
        check("ready_wait", {31'd0, note_ready}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Sends one event and observes until note_ready returns (cycle counts are
    // relative to the accepting edge).
    task automatic play(input logic on, input logic [6:0] num,
                        output int ls, output int lr, output int ns,
                        output logic [2:0] v, output logic g, output logic s,
                        output logic [6:0] n, output logic [7:0] act);
        ls = -1; lr = -1; ns = 0;
        v = '0; g = 1'b0; s = 1'b0; n = '0; act = '0;
        wait_ready();
        note_valid = 1'b1;
        note_on    = on;
        note_num   = num;
        @(posedge clk);
        @(negedge clk);
        note_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (upd_strobe) begin
                ns++;
                if (ls < 0) begin
                    ls = c; v = upd_voice; g = upd_gate; s = upd_steal;
                    n = upd_note; act = voice_active;
                end
            end
            if (note_ready) begin
                lr = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic expect_upd(input string tag, input logic on, input logic [6:0] num,
                              input logic [2:0] ev, input logic es, input logic [7:0] eact);
        int ls, lr, ns;
        logic [2:0] v;
        logic g, s;
        logic [6:0] n;
        logic [7:0] act;
        play(on, num, ls, lr, ns, v, g, s, n, act);
        check({tag, ".lat"},   ls, 32'd9);
        check({tag, ".rdy"},   lr, 32'd10);
        check({tag, ".nstb"},  ns, 32'd1);
        check({tag, ".voice"}, {29'd0, v}, {29'd0, ev});
        check({tag, ".gate"},  {31'd0, g}, {31'd0, on});
        check({tag, ".steal"}, {31'd0, s}, {31'd0, es});
        check({tag, ".note"},  {25'd0, n}, {25'd0, num});
        check({tag, ".act"},   {24'd0, act}, {24'd0, eact});
    endtask

    initial begin
        int ls, lr, ns, extra;
        logic [2:0] v;
        logic g, s;
        logic [6:0] n;
        logic [7:0] act;

        rst = 1'b1; note_valid = 1'b0; note_on = 1'b0; note_num = '0;
        repeat (3) @(negedge clk);
        check("rst.ready",  {31'd0, note_ready}, 32'd0);
        check("rst.strobe", {31'd0, upd_strobe}, 32'd0);
        check("rst.steal",  {31'd0, upd_steal}, 32'd0);
        check("rst.gate",   {31'd0, upd_gate}, 32'd0);
        check("rst.voice",  {29'd0, upd_voice}, 32'd0);
        check("rst.note",   {25'd0, upd_note}, 32'd0);
        check("rst.act",    {24'd0, voice_active}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst.ready_release", {31'd0, note_ready}, 32'd1);

        // Basic allocation, release and reuse
        expect_upd("on60", 1'b1, 7'd60, 3'd0, 1'b0, 8'h01);
        expect_upd("on62", 1'b1, 7'd62, 3'd1, 1'b0, 8'h03);
        expect_upd("on64", 1'b1, 7'd64, 3'd2, 1'b0, 8'h07);
        expect_upd("off62", 1'b0, 7'd62, 3'd1, 1'b0, 8'h05);
        expect_upd("on70", 1'b1, 7'd70, 3'd1, 1'b0, 8'h07);

        // Fill all voices, then steal round-robin through a full wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            expect_upd("fill", 1'b1, 7'(40 + i), 3'(i), 1'b0, 8'((16'd1 << (i + 1)) - 16'd1));
        end
        for (int i = 0; i < 8; i++) begin
            expect_upd("steal", 1'b1, 7'(50 + i), 3'(i), 1'b1, 8'hFF);
        end
        expect_upd("steal_wrap", 1'b1, 7'd58, 3'd0, 1'b1, 8'hFF);

        // Retrigger takes precedence over a free voice; unmatched note-off
        do_reset();
        expect_upd("r10", 1'b1, 7'd10, 3'd0, 1'b0, 8'h01);
        expect_upd("r11", 1'b1, 7'd11, 3'd1, 1'b0, 8'h03);
        expect_upd("r12", 1'b1, 7'd12, 3'd2, 1'b0, 8'h07);
        expect_upd("r60", 1'b1, 7'd60, 3'd3, 1'b0, 8'h0F);
        expect_upd("retrig60", 1'b1, 7'd60, 3'd3, 1'b0, 8'h0F);
        play(1'b0, 7'd99, ls, lr, ns, v, g, s, n, act);
        check("off99.nstb", ns, 32'd0);
        check("off99.rdy",  lr, 32'd9);
        check("off99.act",  {24'd0, voice_active}, 32'h0F);
        expect_upd("on80", 1'b1, 7'd80, 3'd4, 1'b0, 8'h1F);

        // Reset in the middle of a scan aborts the event
        wait_ready();
        note_valid = 1'b1; note_on = 1'b1; note_num = 7'd20;
        @(posedge clk);
        @(negedge clk);
        note_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        extra = 0;
        repeat (2) begin
            @(negedge clk);
            if (upd_strobe) extra++;
        end
        check("abort.act",   {24'd0, voice_active}, 32'd0);
        check("abort.ready_in_rst", {31'd0, note_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort.ready", {31'd0, note_ready}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            if (upd_strobe) extra++;
            @(negedge clk);
        end
        check("abort.nstb", extra, 32'd0);

        // A note_valid pulse while busy is dropped
        wait_ready();
        note_valid = 1'b1; note_on = 1'b1; note_num = 7'd30;
        @(posedge clk);
        @(negedge clk);
        note_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("drop.busy", {31'd0, note_ready}, 32'd0);
        note_valid = 1'b1; note_num = 7'd31;
        @(negedge clk);
        note_valid = 1'b0;
        ls = -1;
        for (int c = 0; c < 20; c++) begin
            if (upd_strobe) begin
                ls = c; v = upd_voice; n = upd_note;
                break;
            end
            @(negedge clk);
        end
        check("drop.seen",  {31'd0, (ls >= 0)}, 32'd1);
        check("drop.voice", {29'd0, v}, 32'd0);
        check("drop.note",  {25'd0, n}, 32'd30);
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (upd_strobe) extra++;
        end
        check("drop.nstb", extra, 32'd0);
        check("drop.act",  {24'd0, voice_active}, 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
